// File: rtl/mem_stream_reader_pkg.sv
// Shared types and sizing helpers for the memory stream reader and its writer counterpart.
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam int WORD_DEF = 8;
  localparam int SIZE_DEF = 256;

  // Address width for a buffer of the given depth; never narrower than one bit.
  function automatic int adr_size(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// Control, memory-port and Avalon-ST source signals of the stream reader.
interface mem_stream_reader_if
  import mem_stream_reader_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int SIZE = SIZE_DEF
) ();

  localparam int ADR_SIZE = adr_size(SIZE);

  logic                start_i;
  logic [ADR_SIZE:0]   length_i;
  logic [ADR_SIZE-1:0] Adr_o;
  logic [WORD-1:0]     DataRd_i;
  logic [WORD-1:0]     src_data_o;
  logic                src_valid_o;
  logic                src_ready_i;
  logic                src_sop_o;
  logic                src_eop_o;
  logic                busy_o;
  logic                done_o;

  modport slave (
    input  start_i, length_i, DataRd_i, src_ready_i,
    output Adr_o, src_data_o, src_valid_o, src_sop_o, src_eop_o, busy_o, done_o
  );

  modport master (
    output start_i, length_i, DataRd_i, src_ready_i,
    input  Adr_o, src_data_o, src_valid_o, src_sop_o, src_eop_o, busy_o, done_o
  );

endinterface

// File: rtl/mem_stream_reader_st_src_reg.sv
// One-entry Avalon-ST source register: holds data/sop/eop stable until the sink accepts.
module st_src_reg #(
  parameter int WORD = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            accept_i,
  input  logic [WORD-1:0] data_i,
  input  logic            sop_i,
  input  logic            eop_i,
  output logic [WORD-1:0] data_o,
  output logic            valid_o,
  output logic            sop_o,
  output logic            eop_o
);

  logic [WORD-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;

  // Load wins over accept: a simultaneous accept+load replaces the drained beat.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      sop_d   = sop_i;
      eop_d   = eop_i;
    end else if (accept_i) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Streams words 0..length-1 of the frame buffer out as a single Avalon-ST packet.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int SIZE = SIZE_DEF
) (
  input logic                clk_i,
  input logic                rst_n_i,
  mem_stream_reader_if.slave bus
);

  localparam int ADR_SIZE = adr_size(SIZE);

  state_e            state_q, state_d;
  logic [ADR_SIZE:0] idx_q, idx_d;
  logic [ADR_SIZE:0] len_q, len_d;
  logic [ADR_SIZE:0] last_idx;
  logic              done_q, done_d;
  logic              load;
  logic              accept;
  logic              is_first;
  logic              is_last;
  logic [WORD-1:0]   src_data;
  logic              src_valid;
  logic              src_sop;
  logic              src_eop;

  // Index is one bit wider than the address so a full-depth packet ends without wrapping.
  assign last_idx = len_q - 1'b1;
  assign is_first = (idx_q == '0);
  assign is_last  = (idx_q == last_idx);
  assign load     = (state_q == ST_STREAM) && (!src_valid || bus.src_ready_i);
  assign accept   = src_valid && bus.src_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.length_i != '0) begin
            len_d   = bus.length_i;
            idx_d   = '0;
            state_d = ST_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (load) begin
          idx_d = idx_q + 1'b1;
          if (is_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Clearing the index here keeps the address bus at 0 whenever idle.
        if (accept) begin
          idx_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  st_src_reg #(
    .WORD (WORD)
  ) u_src_reg (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (load),
    .accept_i (accept),
    .data_i   (bus.DataRd_i),
    .sop_i    (is_first),
    .eop_i    (is_last),
    .data_o   (src_data),
    .valid_o  (src_valid),
    .sop_o    (src_sop),
    .eop_o    (src_eop)
  );

  assign bus.Adr_o       = idx_q[ADR_SIZE-1:0];
  assign bus.src_data_o  = src_data;
  assign bus.src_valid_o = src_valid;
  assign bus.src_sop_o   = src_sop;
  assign bus.src_eop_o   = src_eop;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: expected beats queued at start, popped on accept.
module tb_mem_stream_reader;

  localparam int WORD = 8;
  localparam int SIZE = 256;

  typedef struct {
    logic [WORD-1:0] data;
    logic            sop;
    logic            eop;
  } beat_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miscmp;
  int   n_acc;
  int   n_eop;

  logic [WORD-1:0] mem [SIZE];
  beat_t           sb [$];
  beat_t           mon_e;
  logic            stall_prev;
  logic [WORD+1:0] held;

  mem_stream_reader_if #(.WORD(WORD), .SIZE(SIZE)) bus ();

  mem_stream_reader #(.WORD(WORD), .SIZE(SIZE)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  assign bus.DataRd_i = mem[bus.Adr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sink-side monitor: stability under backpressure and in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bus.src_valid_o), 32'd1);
        chk("hold_beat", 32'({bus.src_sop_o, bus.src_eop_o, bus.src_data_o}), 32'(held));
      end
      if (bus.src_valid_o && bus.src_ready_i) begin
        n_acc++;
        if (bus.src_eop_o) n_eop++;
        if (sb.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("beat_data", 32'(bus.src_data_o), 32'(mon_e.data));
          chk("beat_sop", 32'(bus.src_sop_o), 32'(mon_e.sop));
          chk("beat_eop", 32'(bus.src_eop_o), 32'(mon_e.eop));
        end
      end
      stall_prev = bus.src_valid_o && !bus.src_ready_i;
      held = {bus.src_sop_o, bus.src_eop_o, bus.src_data_o};
    end
  end

  // One packet: optional stall of stall_n cycles on beat stall_beat, optional
  // ignored start pulse spur_off cycles after the real one.
  task automatic run_pkt(input int len, input int stall_beat, input int stall_n, input int spur_off);
    int t0;
    int tdone;
    int stall_left;
    int max_adr;
    int acc0;
    bit got;
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = mem[i];
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      sb.push_back(b);
    end
    acc0 = n_acc;
    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.length_i    = 9'(len);
    bus.src_ready_i = 1'b1;
    t0         = cyc;
    stall_left = stall_n;
    max_adr    = -1;
    got        = 1'b0;
    tdone      = 0;
    for (int c = 0; c < 800 && !got; c++) begin
      @(posedge clk); #1;
      bus.start_i = (spur_off > 0) && (cyc == t0 + spur_off);
      if (bus.start_i) bus.length_i = 9'd2;
      if (cyc == t0 + 1) chk("busy_t1", 32'(bus.busy_o), 32'(len > 0));
      if (cyc == t0 + 2 && len > 0) chk("first_sop", 32'({bus.src_valid_o, bus.src_sop_o}), 32'b11);
      if (bus.busy_o && !(bus.src_valid_o && bus.src_eop_o) && int'(bus.Adr_o) > max_adr)
        max_adr = int'(bus.Adr_o);
      if (bus.src_valid_o && (n_acc - acc0) == stall_beat && stall_left > 0) begin
        bus.src_ready_i = 1'b0;
        if (stall_beat + 1 < len) chk("stall_adr", 32'(bus.Adr_o), 32'(stall_beat + 1));
        stall_left--;
      end else begin
        bus.src_ready_i = 1'b1;
      end
      if (bus.done_o) begin
        got   = 1'b1;
        tdone = cyc;
      end
    end
    bus.start_i = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("done_cycle", 32'(tdone - t0), 32'((len == 0) ? 1 : len + 2 + stall_n));
      chk("busy_at_done", 32'(bus.busy_o), 32'd0);
      chk("valid_at_done", 32'(bus.src_valid_o), 32'd0);
    end
    chk("beats_sent", 32'(n_acc - acc0), 32'(len));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    if (len > 0) chk("last_adr", 32'(max_adr), 32'(len - 1));
    sb.delete();
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done_o), 32'd0);
    chk("idle_adr", 32'(bus.Adr_o), 32'd0);
  endtask

  initial begin
    int t0;
    int eop0;
    beat_t b;
    n_vec = 0;
    n_miscmp = 0;
    n_acc = 0;
    n_eop = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(16'h10 + i);
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.length_i    = '0;
    bus.src_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({bus.src_valid_o, bus.src_sop_o, bus.src_eop_o, bus.busy_o, bus.done_o}), 32'd0);
    chk("rst_adr", 32'(bus.Adr_o), 32'd0);
    chk("rst_data", 32'(bus.src_data_o), 32'd0);
    rst_n = 1'b1;

    run_pkt(4, -1, 0, 0);
    run_pkt(3, 1, 3, 0);
    run_pkt(1, -1, 0, 0);
    run_pkt(0, -1, 0, 0);
    run_pkt(256, -1, 0, 0);
    run_pkt(4, -1, 0, 2);
    run_pkt(6, 3, 2, 0);

    // Reset in the middle of a 5-word packet after beats 0 and 1 are accepted.
    for (int i = 0; i < 2; i++) begin
      b.data = mem[i];
      b.sop  = (i == 0);
      b.eop  = 1'b0;
      sb.push_back(b);
    end
    eop0 = n_eop;
    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.length_i    = 9'd5;
    bus.src_ready_i = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    while (cyc < t0 + 4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ctrl", 32'({bus.src_valid_o, bus.src_sop_o, bus.src_eop_o, bus.busy_o, bus.done_o}), 32'd0);
    chk("midrst_adr", 32'(bus.Adr_o), 32'd0);
    chk("midrst_data", 32'(bus.src_data_o), 32'd0);
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    chk("midrst_no_eop", 32'(n_eop), 32'(eop0));
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_pkt(3, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
